// File: rtl/fc_pkg.sv
// fc_pkg: state encoding and numeric constants shared by the FC1 layer.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } fc_state_t;

    localparam int ACC_W = 32;

    localparam logic signed [ACC_W-1:0] Q_MAX = 127;
    localparam logic signed [ACC_W-1:0] Q_MIN = -128;

endpackage

// File: rtl/fc_requant.sv
// fc_requant: shift, saturate to int8; clamps negatives to zero when
// FC1_RELU_EN is defined.
module fc_requant
    import fc_pkg::*;
#(
    parameter int SHIFT = 7
) (
    input  logic [ACC_W-1:0] acc,
    output logic [7:0]       q
);

    logic signed [ACC_W-1:0] sh;

    always_comb begin
        sh = $signed(acc) >>> SHIFT;
        if (sh > Q_MAX) begin
            q = Q_MAX[7:0];
        end else if (sh < Q_MIN) begin
            q = Q_MIN[7:0];
        end else begin
            q = sh[7:0];
        end
`ifdef FC1_RELU_EN
        if (q[7]) begin
            q = 8'h00;
        end
`endif
    end

endmodule

// File: rtl/fc_flat_reader.sv
// fc_flat_reader: FC1 layer over the flattened pooled vector in RAM.
// Optional ReLU on the written outputs via FC1_RELU_EN.
module fc_flat_reader
    import fc_pkg::*;
#(
    parameter int          IN_N     = 1600,
    parameter int          OUT_N    = 10,
    parameter logic [15:0] IN_BASE  = 16'd0,
    parameter logic [15:0] OUT_BASE = 16'd1600,
    parameter int          RD_LAT   = 2,
    parameter int          SHIFT    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_FC1,
    output logic        end_FC1,
    output logic [15:0] ram_addr_r,
    output logic        ram_en_r,
    input  logic [7:0]  ram_data_r,
    output logic [15:0] rom_addr,
    output logic        rom_en,
    input  logic [31:0] rom_data,
    output logic [15:0] ram_addr_w,
    output logic [7:0]  ram_data_w,
    output logic        ram_en,
    output logic        ram_wea
);

    localparam int KW = $clog2(IN_N + 1);
    localparam int NW = $clog2(OUT_N + 1);
    localparam int WW = $clog2(RD_LAT + 1);
    localparam logic [15:0] BIAS_BASE = 16'(OUT_N * IN_N);

    fc_state_t state, state_nx;

    logic [KW-1:0]           k;
    logic [NW-1:0]           n;
    logic [WW-1:0]           wcnt;
    logic [RD_LAT-1:0]       vld;
    logic signed [ACC_W-1:0] acc;
    logic signed [15:0]      prod;
    logic [7:0]              q;
    logic                    k_last, n_last, w_bias, w_drain, issue;

    assign k_last  = (k == KW'(IN_N - 1));
    assign n_last  = (n == NW'(OUT_N - 1));
    assign w_bias  = (wcnt == WW'(RD_LAT));
    assign w_drain = (wcnt == WW'(RD_LAT - 1));
    assign issue   = (state == MAC);
    assign prod    = $signed(ram_data_r) * $signed(rom_data[7:0]);

    fc_requant #(
        .SHIFT(SHIFT)
    ) u_rq (
        .acc(acc),
        .q  (q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ram_addr_r = '0;
        ram_en_r   = 1'b0;
        rom_addr   = '0;
        rom_en     = 1'b0;
        ram_addr_w = '0;
        ram_data_w = '0;
        ram_en     = 1'b0;
        ram_wea    = 1'b0;
        end_FC1    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_FC1) state_nx = BIAS;
            end
            BIAS: begin
                // bias is fetched once, then waited on for RD_LAT cycles
                if (wcnt == '0) begin
                    rom_en   = 1'b1;
                    rom_addr = BIAS_BASE + 16'(n);
                end
                if (w_bias) state_nx = MAC;
            end
            MAC: begin
                ram_en_r   = 1'b1;
                ram_addr_r = IN_BASE + 16'(k);
                rom_en     = 1'b1;
                rom_addr   = 16'(n) * 16'(IN_N) + 16'(k);
                if (k_last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (w_drain) state_nx = WRITE;
            end
            WRITE: begin
                ram_en     = 1'b1;
                ram_wea    = 1'b1;
                ram_addr_w = OUT_BASE + 16'(n);
                ram_data_w = q;
                state_nx   = n_last ? DONE : BIAS;
            end
            DONE: begin
                end_FC1  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k    <= '0;
            n    <= '0;
            wcnt <= '0;
            vld  <= '0;
            acc  <= '0;
        end else begin
            vld <= (vld << 1) | RD_LAT'(issue);
            if (vld[RD_LAT-1]) begin
                acc <= acc + {{(ACC_W-16){prod[15]}}, prod};
            end
            unique case (state)
                IDLE: begin
                    if (start_FC1) begin
                        n    <= '0;
                        k    <= '0;
                        wcnt <= '0;
                    end
                end
                BIAS: begin
                    if (w_bias) begin
                        acc  <= $signed(rom_data);
                        wcnt <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                MAC: k <= k_last ? '0 : k + 1'b1;
                DRAIN: wcnt <= w_drain ? '0 : wcnt + 1'b1;
                WRITE: begin
                    if (!n_last) n <= n + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_flat_reader.sv
// tb_fc_flat_reader: directed vectors for fc_flat_reader on a 4x2 (shift 0)
// and a 1x1 (shift 7) instance with RD_LAT=2 memory models.
module tb_fc_flat_reader;

    localparam int          NA  = 4;
    localparam int          MA  = 2;
    localparam logic [15:0] IBA = 16'd8;
    localparam logic [15:0] OBA = 16'd100;
    localparam logic [15:0] IBB = 16'd3;
    localparam logic [15:0] OBB = 16'd20;
    localparam int          LAT_A = MA * (1 + 2 + NA + 2 + 1) + 1;
    localparam int          LAT_B = 1 * (1 + 2 + 1 + 2 + 1) + 1;

    typedef struct packed {
        logic [0:3][7:0]      act;
        logic [0:1][0:3][7:0] w;
        logic [0:1][31:0]     b;
        logic [0:1][7:0]      ex;
    } vec_a_t;

    typedef struct packed {
        logic [7:0]  act;
        logic [7:0]  w;
        logic [31:0] b;
        logic [7:0]  ex;
    } vec_b_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start   [2];
    logic        endp    [2];
    logic [15:0] raddr   [2];
    logic [15:0] romaddr [2];
    logic [15:0] waddr   [2];
    logic        ren     [2];
    logic        romen   [2];
    logic        wen     [2];
    logic        wea     [2];
    logic [7:0]  rdata   [2];
    logic [7:0]  wdata   [2];
    logic [31:0] romdata [2];

    fc_flat_reader #(
        .IN_N(NA), .OUT_N(MA), .IN_BASE(IBA), .OUT_BASE(OBA),
        .RD_LAT(2), .SHIFT(0)
    ) u_a (
        .clk(clk), .rst_n(rst_n),
        .start_FC1(start[0]), .end_FC1(endp[0]),
        .ram_addr_r(raddr[0]), .ram_en_r(ren[0]), .ram_data_r(rdata[0]),
        .rom_addr(romaddr[0]), .rom_en(romen[0]), .rom_data(romdata[0]),
        .ram_addr_w(waddr[0]), .ram_data_w(wdata[0]),
        .ram_en(wen[0]), .ram_wea(wea[0])
    );

    fc_flat_reader #(
        .IN_N(1), .OUT_N(1), .IN_BASE(IBB), .OUT_BASE(OBB),
        .RD_LAT(2), .SHIFT(7)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .start_FC1(start[1]), .end_FC1(endp[1]),
        .ram_addr_r(raddr[1]), .ram_en_r(ren[1]), .ram_data_r(rdata[1]),
        .rom_addr(romaddr[1]), .rom_en(romen[1]), .rom_data(romdata[1]),
        .ram_addr_w(waddr[1]), .ram_data_w(wdata[1]),
        .ram_en(wen[1]), .ram_wea(wea[1])
    );

    logic [7:0]  ram_m [2][32];
    logic [31:0] rom_m [2][16];
    logic [7:0]  rd1   [2];
    logic [31:0] ro1   [2];

    // two-stage read pipelines; idle reads return junk to expose mistagging
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            rd1[u] <= (ren[u] && raddr[u] < 32) ? ram_m[u][raddr[u][4:0]] : 8'h5A;
            rdata[u] <= rd1[u];
            ro1[u] <= (romen[u] && romaddr[u] < 16) ? rom_m[u][romaddr[u][3:0]] : 32'h7777_7777;
            romdata[u] <= ro1[u];
        end
    end

    int         wcount [2] = '{0, 0};
    int         ecount [2] = '{0, 0};
    int         bad = 0;
    logic [15:0] wlog_a [2][64];
    logic [7:0]  wlog_d [2][64];

    function automatic bit addr_ok(input int u);
        int inn;
        int outn;
        int ib;
        int ob;
        bit ok;
        inn  = (u == 0) ? NA : 1;
        outn = (u == 0) ? MA : 1;
        ib   = (u == 0) ? int'(IBA) : int'(IBB);
        ob   = (u == 0) ? int'(OBA) : int'(OBB);
        ok   = 1'b1;
        if (ren[u] && (int'(raddr[u]) < ib || int'(raddr[u]) > ib + inn - 1)) ok = 1'b0;
        if (romen[u] && int'(romaddr[u]) > inn * outn + outn - 1) ok = 1'b0;
        if (wen[u] && (int'(waddr[u]) < ob || int'(waddr[u]) > ob + outn - 1)) ok = 1'b0;
        return ok;
    endfunction

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (wen[u] && wea[u]) begin
                wlog_a[u][wcount[u] % 64] <= waddr[u];
                wlog_d[u][wcount[u] % 64] <= wdata[u];
                wcount[u] <= wcount[u] + 1;
            end
            if (endp[u]) ecount[u] <= ecount[u] + 1;
            if (!addr_ok(u)) bad <= bad + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic logic [7:0] eff(input logic [7:0] v);
`ifdef FC1_RELU_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] model(input logic [0:3][7:0] a, input logic [0:3][7:0] w,
                                         input logic [31:0] b, input int len, input int sh);
        logic signed [31:0] acc;
        logic signed [31:0] q;
        acc = b;
        for (int k = 0; k < len; k++) acc = acc + $signed(a[k]) * $signed(w[k]);
        q = acc >>> sh;
        if (q > 127) q = 127;
        else if (q < -128) q = -128;
        return eff(q[7:0]);
    endfunction

    task automatic load_a(input vec_a_t v);
        for (int k = 0; k < NA; k++) ram_m[0][int'(IBA) + k] = v.act[k];
        for (int n = 0; n < MA; n++) begin
            for (int k = 0; k < NA; k++) rom_m[0][n * NA + k] = {24'hA5C3E1, v.w[n][k]};
            rom_m[0][NA * MA + n] = v.b[n];
        end
    endtask

    task automatic load_b(input vec_b_t v);
        ram_m[1][int'(IBB)] = v.act;
        rom_m[1][0] = {24'hA5C3E1, v.w};
        rom_m[1][1] = v.b;
    endtask

    task automatic run(input int u, input int nout, input int exp_lat,
                       input string nm, output int w0);
        int lat;
        int e0;
        w0 = wcount[u];
        e0 = ecount[u];
        @(negedge clk);
        start[u] = 1'b1;
        @(posedge clk);
        #1;
        start[u] = 1'b0;
        lat = 1;
        while (endp[u] !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, ".lat"}, lat, exp_lat);
        @(posedge clk);
        #1;
        chk({nm, ".pulse"}, {31'd0, endp[u]}, 0);
        @(negedge clk);
        chk({nm, ".nwr"}, wcount[u] - w0, nout);
        chk({nm, ".nend"}, ecount[u] - e0, 1);
    endtask

    initial begin
        vec_a_t va [5];
        vec_b_t vb [5];
        int w0;
        int w0b;
        int e0;
        int lat;

        start[0] = 1'b0;
        start[1] = 1'b0;
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 32; i++) ram_m[u][i] = 8'h00;
            for (int i = 0; i < 16; i++) rom_m[u][i] = 32'h0;
        end

        va[0] = '{act: {8'd1, 8'd2, 8'd3, 8'd4},
                  w: {8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd0, 8'd0, -8'sd1},
                  b: {32'd0, 32'd0}, ex: {8'h0A, 8'hFE}};
        va[1] = '{act: {8'd127, 8'd127, 8'd127, 8'd127},
                  w: {8'd127, 8'd127, 8'd127, 8'd127, 8'h80, 8'h80, 8'h80, 8'h80},
                  b: {32'd0, 32'd0}, ex: {8'h7F, 8'h80}};
        va[2] = '{act: {8'd0, 8'd0, 8'd0, 8'd0},
                  w: {8'd3, 8'd3, 8'd3, 8'd3, -8'sd7, -8'sd7, -8'sd7, -8'sd7},
                  b: {-32'sd300, 32'sd5}, ex: {8'h80, 8'h05}};
        va[3] = '{act: {-8'sd1, 8'sd2, -8'sd3, 8'sd4},
                  w: {8'sd5, -8'sd6, 8'sd7, -8'sd8, 8'd1, 8'd1, 8'd1, 8'd1},
                  b: {32'sd10, -32'sd2}, ex: {8'hC4, 8'h00}};
        va[4] = '{act: {8'sd100, -8'sd100, 8'sd50, -8'sd50},
                  w: {8'd1, 8'd1, 8'd1, 8'd1, 8'sd1, -8'sd1, 8'sd1, -8'sd1},
                  b: {32'sd27, -32'sd200}, ex: {8'h1B, 8'h64}};

        vb[0] = '{act: 8'd64, w: 8'd64, b: 32'd0, ex: 8'h20};
        vb[1] = '{act: -8'sd64, w: 8'd64, b: 32'd0, ex: 8'hE0};
        vb[2] = '{act: 8'd1, w: 8'd1, b: -32'sd2, ex: 8'hFF};
        vb[3] = '{act: 8'd127, w: 8'd127, b: 32'sd32767, ex: 8'h7F};
        vb[4] = '{act: 8'h80, w: 8'd127, b: -32'sd20000, ex: 8'h80};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", {27'd0, ren[0], romen[0], wen[0], wea[0], endp[0]}, 0);
        chk("rst_raddr", {raddr[0], romaddr[0]}, 0);
        chk("rst_waddr", {8'd0, waddr[0], wdata[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            load_a(va[i]);
            run(0, MA, LAT_A, $sformatf("a%0d", i), w0);
            for (int n = 0; n < MA; n++) begin
                chk($sformatf("a%0d.addr%0d", i, n), {16'd0, wlog_a[0][(w0 + n) % 64]}, OBA + n);
                chk($sformatf("a%0d.data%0d", i, n), {24'd0, wlog_d[0][(w0 + n) % 64]},
                    {24'd0, eff(va[i].ex[n])});
            end
        end

        for (int i = 0; i < 5; i++) begin
            load_b(vb[i]);
            run(1, 1, LAT_B, $sformatf("b%0d", i), w0);
            chk($sformatf("b%0d.addr", i), {16'd0, wlog_a[1][w0 % 64]}, {16'd0, OBB});
            chk($sformatf("b%0d.data", i), {24'd0, wlog_d[1][w0 % 64]}, {24'd0, eff(vb[i].ex)});
        end

        // start held high through DONE restarts straight from IDLE
        load_b(vb[0]);
        e0 = ecount[1];
        @(negedge clk);
        start[1] = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        while (endp[1] !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold.first", lat, LAT_B);
        @(posedge clk);
        #1;
        lat = 1;
        while (endp[1] !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold.second", lat, LAT_B + 1);
        start[1] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("hold.ends", ecount[1] - e0, 2);

        // reset during MAC of neuron 0 aborts with no write or end pulse
        load_a(va[3]);
        e0  = ecount[0];
        w0b = wcount[0];
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort.inmac", {31'd0, ren[0]}, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort.en", {27'd0, ren[0], romen[0], wen[0], wea[0], endp[0]}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("abort.nwr", wcount[0] - w0b, 0);
        chk("abort.nend", ecount[0] - e0, 0);

        run(0, MA, LAT_A, "rec", w0);
        for (int n = 0; n < MA; n++) begin
            chk($sformatf("rec.data%0d", n), {24'd0, wlog_d[0][(w0 + n) % 64]},
                {24'd0, model(va[3].act, va[3].w[n], va[3].b[n], NA, 0)});
        end

        chk("addr_range", bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
